// File: rtl/fifo_pkg.sv
// Shared widths, mask bit positions and half-state encodings for the 64-to-32 downsizer.
package fifo_pkg;

  localparam int HALF_W  = 32;
  localparam int WORD_W  = 64;
  localparam int MASK_HI = 1;
  localparam int MASK_LO = 0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HI    = 2'd1;
  localparam logic [1:0] ST_LO    = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_HI    = ST_HI,
    S_LO    = ST_LO
  } half_state_e;

  // The upper half always leaves first, so a pending upper half defines the state.
  function automatic half_state_e decode_state(input logic [1:0] pend);
    if (pend[MASK_HI]) return S_HI;
    if (pend[MASK_LO]) return S_LO;
    return S_EMPTY;
  endfunction

endpackage

// File: rtl/fifo_1d_64to32_entry.sv
// One 64-bit storage entry with per-half pending flags; clear beats load beats consume.
module fifo_1d_64to32_entry
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic [1:0]        load_mask,
  input  logic              consume,
  output logic [WORD_W-1:0] word,
  output logic [1:0]        pend
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        pend_q, pend_d;

  always_comb begin
    word_d = load ? load_word : word_q;
    pend_d = pend_q;
    if (clr) begin
      pend_d = 2'b00;
    end else if (load) begin
      pend_d = load_mask;
    end else if (consume) begin
      if (pend_q[MASK_HI]) pend_d[MASK_HI] = 1'b0;
      else                 pend_d[MASK_LO] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 2'b00;
    else     pend_q <= pend_d;
  end

  // Data is qualified by the pending flags, so it needs no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign word = word_q;
  assign pend = pend_q;

endmodule

// File: rtl/fifo_1d_64to32.sv
// 64-bit to 32-bit width downsizer, upper half first, with per-beat half mask.
// Define FIFO_1D_64TO32_SKID_EN to add a skid entry and a registered a_ready.
module fifo_1d_64to32
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [WORD_W-1:0] a_data,
  input  logic [1:0]        a_mask,
  input  logic              a_valid,
  output logic              a_ready,
  output logic [HALF_W-1:0] b_data,
  output logic              b_valid,
  input  logic              b_ready
);

  logic [WORD_W-1:0] main_word, main_load_word;
  logic [1:0]        main_pend, main_load_mask;
  half_state_e       main_state;
  logic              main_load, last_half, main_free, b_fire, accept;

  assign main_state = decode_state(main_pend);
  assign last_half  = (main_state == S_LO) | ((main_state == S_HI) & !main_pend[MASK_LO]);
  assign b_valid    = |main_pend;
  assign b_data     = (main_state == S_HI) ? main_word[WORD_W-1:HALF_W] : main_word[HALF_W-1:0];
  assign b_fire     = b_valid & b_ready;
  assign main_free  = (main_state == S_EMPTY) | (b_fire & last_half);
  // Mask-00 beats complete the handshake but never touch storage.
  assign accept     = a_valid & a_ready & !flush & (|a_mask);

`ifdef FIFO_1D_64TO32_SKID_EN
  logic [WORD_W-1:0] skid_word;
  logic [1:0]        skid_pend;
  logic              skid_full, skid_move, skid_load;
  logic              a_ready_q, a_ready_d;

  assign skid_full      = |skid_pend;
  assign skid_move      = main_free & skid_full;
  assign skid_load      = accept & !(main_free & !skid_full);
  assign main_load      = skid_move | (accept & main_free & !skid_full);
  assign main_load_word = skid_move ? skid_word : a_data;
  assign main_load_mask = skid_move ? skid_pend : a_mask;

  always_comb begin
    a_ready_d = !(skid_load | (skid_full & !skid_move));
  end

  // a_ready tracks next-cycle skid occupancy so it never depends on b_ready.
  always_ff @(posedge clk) begin
    if (rst || flush) a_ready_q <= 1'b1;
    else              a_ready_q <= a_ready_d;
  end

  assign a_ready = a_ready_q | flush;

  fifo_1d_64to32_entry u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush | skid_move),
    .load      (skid_load),
    .load_word (a_data),
    .load_mask (a_mask),
    .consume   (1'b0),
    .word      (skid_word),
    .pend      (skid_pend)
  );
`else
  assign main_load      = accept;
  assign main_load_word = a_data;
  assign main_load_mask = a_mask;
  assign a_ready        = flush | (main_state == S_EMPTY) | (b_ready & last_half);
`endif

  fifo_1d_64to32_entry u_main (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .load      (main_load),
    .load_word (main_load_word),
    .load_mask (main_load_mask),
    .consume   (b_fire),
    .word      (main_word),
    .pend      (main_pend)
  );

endmodule

// File: tb/tb_fifo_1d_64to32.sv
// Self-checking bench for fifo_1d_64to32: directed scenarios plus randomized traffic against a half-word queue model.
module tb_fifo_1d_64to32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [63:0] a_data = '0;
  logic [1:0]  a_mask = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  bit          lq[$];

  logic [63:0] stream_words[$];
  logic [1:0]  stream_masks[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];

  always #5 clk = ~clk;

  fifo_1d_64to32 dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .a_data  (a_data),
    .a_mask  (a_mask),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready)
  );

  function automatic int beats_held();
    int n = 0;
    foreach (lq[i]) if (lq[i]) n++;
    return n;
  endfunction

  // Expected a_ready this cycle, from the queue of outstanding halves.
  function automatic bit exp_a_ready();
    if (flush) return 1'b1;
`ifdef FIFO_1D_64TO32_SKID_EN
    return beats_held() < 2;
`else
    return (mq.size() == 0) || (b_ready && lq[0]);
`endif
  endfunction

  task automatic model_edge();
    bit ar;
    ar = exp_a_ready();
    if (rst || flush) begin
      mq.delete();
      lq.delete();
      return;
    end
    if (mq.size() > 0 && b_ready) begin
      void'(mq.pop_front());
      void'(lq.pop_front());
    end
    if (a_valid && ar && a_mask != 2'b00) begin
      if (a_mask[1]) begin mq.push_back(a_data[63:32]); lq.push_back(!a_mask[0]); end
      if (a_mask[0]) begin mq.push_back(a_data[31:0]);  lq.push_back(1'b1); end
    end
  endtask

  task automatic apply_stimulus(input bit rs, input bit fl, input bit av,
                                input logic [63:0] ad, input logic [1:0] am, input bit br);
    @(posedge clk);
    #1;
    rst = rs; flush = fl; a_valid = av; a_data = ad; a_mask = am; b_ready = br;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, 0, 0, '0, 2'b00, 0);
      @(negedge clk);
      model_edge();
    end
  endtask

  // Presents stream_words in order with b_ready high and records every output transfer.
  task automatic run_stream(input int ncyc);
    int idx = 0;
    obs_data.delete();
    obs_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (idx < stream_words.size()) apply_stimulus(0, 0, 1, stream_words[idx], stream_masks[idx], 1);
      else                           apply_stimulus(0, 0, 0, '0, 2'b00, 1);
      @(negedge clk);
      if (b_valid === 1'b1) begin obs_data.push_back(b_data); obs_cyc.push_back(c); end
      if (a_valid && exp_a_ready()) idx++;
      model_edge();
    end
  endtask

  task automatic test_reset();
    do_reset();
    apply_stimulus(0, 0, 0, '0, 2'b00, 0);
    @(negedge clk);
    checks++;
    if (b_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_valid got %b expected 0", b_valid); end
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_a_ready got %b expected 1", a_ready); end
    model_edge();
  endtask

  task automatic test_basic();
    do_reset();
    apply_stimulus(0, 0, 1, 64'h11112222_33334444, 2'b11, 1);
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept_ready got %b expected 1", a_ready); end
    model_edge();
    apply_stimulus(0, 0, 0, '0, 2'b00, 1);
    @(negedge clk);
    checks++;
    if (b_valid !== 1'b1 || b_data !== 32'h11112222)
      begin errors++; $display("[TB] FAIL basic_hi got %b/%h expected 1/11112222", b_valid, b_data); end
    checks++;
`ifdef FIFO_1D_64TO32_SKID_EN
    if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_hi_ready got %b expected 1", a_ready); end
`else
    if (a_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_hi_ready got %b expected 0", a_ready); end
`endif
    model_edge();
    apply_stimulus(0, 0, 0, '0, 2'b00, 1);
    @(negedge clk);
    checks++;
    if (b_valid !== 1'b1 || b_data !== 32'h33334444)
      begin errors++; $display("[TB] FAIL basic_lo got %b/%h expected 1/33334444", b_valid, b_data); end
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_lo_ready got %b expected 1", a_ready); end
    model_edge();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_seq[4];
    exp_seq = '{32'hAAAA0001, 32'hAAAA0002, 32'hBBBB0001, 32'hBBBB0002};
    do_reset();
    stream_words = '{64'hAAAA0001_AAAA0002, 64'hBBBB0001_BBBB0002};
    stream_masks = '{2'b11, 2'b11};
    run_stream(8);
    checks++;
    if (obs_data.size() != 4) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 4", obs_data.size()); end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_seq[i])
        begin errors++; $display("[TB] FAIL b2b_data[%0d] got %h expected %h", i, obs_data[i], exp_seq[i]); end
    end
    if (obs_cyc.size() == 4) begin
      checks++;
      if (obs_cyc[3] - obs_cyc[0] != 3)
        begin errors++; $display("[TB] FAIL b2b_bubbles span got %0d expected 3", obs_cyc[3] - obs_cyc[0]); end
    end
  endtask

  task automatic test_masks();
    do_reset();
    stream_words = '{64'h00000001_00000002, 64'h00000003_00000004, 64'h00000005_00000006};
    stream_masks = '{2'b01, 2'b10, 2'b00};
    run_stream(8);
    checks++;
    if (obs_data.size() != 2) begin errors++; $display("[TB] FAIL masks_count got %0d expected 2", obs_data.size()); end
    if (obs_data.size() >= 2) begin
      checks++;
      if (obs_data[0] !== 32'h00000002 || obs_data[1] !== 32'h00000003)
        begin errors++; $display("[TB] FAIL masks_data got %h,%h expected 00000002,00000003", obs_data[0], obs_data[1]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_rel[2];
    exp_rel = '{32'hCAFE0001, 32'hBEEF0002};
    do_reset();
    apply_stimulus(0, 0, 1, 64'hCAFE0001_BEEF0002, 2'b11, 0);
    @(negedge clk);
    model_edge();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 0, 0, '0, 2'b00, 0);
      @(negedge clk);
      checks++;
      if (b_valid !== 1'b1 || b_data !== 32'hCAFE0001)
        begin errors++; $display("[TB] FAIL stall_hold[%0d] got %b/%h expected 1/cafe0001", i, b_valid, b_data); end
      checks++;
      if (a_ready !== exp_a_ready())
        begin errors++; $display("[TB] FAIL stall_ready[%0d] got %b expected %b", i, a_ready, exp_a_ready()); end
      model_edge();
    end
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0, 0, 0, '0, 2'b00, 1);
      @(negedge clk);
      checks++;
      if (b_valid !== 1'b1 || b_data !== exp_rel[i])
        begin errors++; $display("[TB] FAIL stall_release[%0d] got %b/%h expected 1/%h", i, b_valid, b_data, exp_rel[i]); end
      model_edge();
    end
    apply_stimulus(0, 0, 0, '0, 2'b00, 1);
    @(negedge clk);
    checks++;
    if (b_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drained got %b expected 0", b_valid); end
    model_edge();
  endtask

  task automatic test_flush();
    do_reset();
    apply_stimulus(0, 0, 1, 64'h12345678_9ABCDEF0, 2'b11, 1);
    @(negedge clk); model_edge();
    apply_stimulus(0, 0, 0, '0, 2'b00, 1);
    @(negedge clk); model_edge();
    apply_stimulus(0, 1, 1, 64'hDEADBEEF_DEADBEEF, 2'b11, 1);
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %b expected 1", a_ready); end
    checks++;
    if (b_valid !== 1'b1 || b_data !== 32'h9ABCDEF0)
      begin errors++; $display("[TB] FAIL flush_lo got %b/%h expected 1/9abcdef0", b_valid, b_data); end
    model_edge();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, '0, 2'b00, 1);
      @(negedge clk);
      checks++;
      if (b_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty[%0d] got %b expected 0", i, b_valid); end
      model_edge();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply_stimulus(0, 0, 1, 64'h55556666_77778888, 2'b11, 0);
    @(negedge clk); model_edge();
    apply_stimulus(1, 0, 0, '0, 2'b00, 0);
    @(negedge clk); model_edge();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, '0, 2'b00, 1);
      @(negedge clk);
      checks++;
      if (b_valid !== 1'b0 || a_ready !== 1'b1)
        begin errors++; $display("[TB] FAIL reset_mid[%0d] got valid %b ready %b expected 0 1", i, b_valid, a_ready); end
      model_edge();
    end
  endtask

  task automatic test_random();
    bit fl, av, br;
    logic [63:0] ad;
    logic [1:0]  am;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fl = ($urandom_range(0, 31) == 0);
      av = ($urandom_range(0, 3) != 0);
      br = ($urandom_range(0, 3) != 0);
      ad = {$urandom, $urandom};
      am = 2'($urandom_range(0, 3));
      apply_stimulus(0, fl, av, ad, am, br);
      @(negedge clk);
      checks++;
      if (b_valid !== (mq.size() > 0))
        begin errors++; $display("[TB] FAIL rand_valid cyc %0d got %b expected %b", c, b_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++;
        if (b_data !== mq[0])
          begin errors++; $display("[TB] FAIL rand_data cyc %0d got %h expected %h", c, b_data, mq[0]); end
      end
      checks++;
      if (a_ready !== exp_a_ready())
        begin errors++; $display("[TB] FAIL rand_ready cyc %0d got %b expected %b", c, a_ready, exp_a_ready()); end
      model_edge();
    end
  endtask

`ifdef FIFO_1D_64TO32_SKID_EN
  task automatic test_skid();
    logic [31:0] exp_seq[4];
    exp_seq = '{32'hA0A0A0A1, 32'hA0A0A0A2, 32'hB0B0B0B1, 32'hB0B0B0B2};
    do_reset();
    apply_stimulus(0, 0, 1, 64'hA0A0A0A1_A0A0A0A2, 2'b11, 0);
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_first_ready got %b expected 1", a_ready); end
    model_edge();
    apply_stimulus(0, 0, 1, 64'hB0B0B0B1_B0B0B0B2, 2'b11, 0);
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_second_ready got %b expected 1", a_ready); end
    model_edge();
    apply_stimulus(0, 0, 0, '0, 2'b00, 0);
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("[TB] FAIL skid_full_ready got %b expected 0", a_ready); end
    model_edge();
    obs_data.delete();
    for (int c = 0; c < 6; c++) begin
      apply_stimulus(0, 0, 0, '0, 2'b00, 1);
      @(negedge clk);
      if (b_valid === 1'b1) obs_data.push_back(b_data);
      checks++;
      if (a_ready !== exp_a_ready())
        begin errors++; $display("[TB] FAIL skid_drain_ready[%0d] got %b expected %b", c, a_ready, exp_a_ready()); end
      model_edge();
    end
    checks++;
    if (obs_data.size() != 4) begin errors++; $display("[TB] FAIL skid_count got %0d expected 4", obs_data.size()); end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_seq[i])
        begin errors++; $display("[TB] FAIL skid_data[%0d] got %h expected %h", i, obs_data[i], exp_seq[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_masks();
    test_stall();
    test_flush();
    test_reset_mid();
`ifdef FIFO_1D_64TO32_SKID_EN
    test_skid();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_1d_64to32.md
Name: fifo_1d_64to32

Overview:
- Width downsizer. Accepts 64-bit beats and emits them as 32-bit beats, upper half [63:32] first, then lower half [31:0].
- It is the inverse of the 32-to-64 packing stage, which places its first word in [63:32].
- Used on 64-bit memory/fetch paths feeding 32-bit consumers (instruction parcels, 32-bit peripherals).
- A per-beat half mask allows an unaligned start or end (e.g. a fetch that begins or ends mid-word).

Parameters:
- None. Widths are fixed at 64 in / 32 out.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous discard of all stored data
- a_data  input  64  incoming word
- a_mask  input  2  half-valid mask; bit1 = [63:32], bit0 = [31:0]
- a_valid  input  1  incoming beat valid
- a_ready  output  1  incoming beat accepted when a_valid && a_ready
- b_data  output  32  outgoing half-word
- b_valid  output  1  outgoing beat valid
- b_ready  input  1  outgoing beat consumed when b_valid && b_ready

Behaviour:
- Storage (base build): one 64-bit word register plus pending flags hi_pend and lo_pend.
- Derived state:
  - EMPTY: no flags set.
  - HI: hi_pend set; lo_pend may also be set.
  - LO: only lo_pend set.
- Outputs:
  - b_valid = hi_pend | lo_pend.
  - b_data = word[63:32] in HI, word[31:0] in LO.
  - b_data is don't-care when b_valid = 0.
- Reset: hi_pend = lo_pend = 0. So b_valid = 0 and a_ready = 1 (see a_ready rule) in the cycle after rst. Data register is not reset.
- last_half = (LO) | (HI & !lo_pend).
- a_ready (base build) = EMPTY | (b_ready & last_half). This is a combinational path from b_ready.
- Accept at cycle t: word <= a_data, hi_pend <= a_mask[1], lo_pend <= a_mask[0]. b_valid rises at t+1. Latency is 1 cycle.
- Output transfer in HI:
  - Clears hi_pend.
  - If lo_pend, the next cycle is LO.
  - Otherwise the entry is freed; a simultaneous accept loads the new word in the same edge.
- Output transfer in LO clears lo_pend; a simultaneous accept loads the new word.
- Sustained throughput: one 64-bit beat per 2 cycles with mask 11; one per cycle with single-half masks.
- a_mask = 00: beat is accepted per the a_ready rule and dropped. No state change, no output.
- flush:
  - Clears both flags at the edge.
  - a_ready is forced to 1 during flush; any beat presented that cycle is discarded.
  - b_valid is not gated combinationally; a b transfer in the flush cycle still counts as consumed.
- rst has priority over flush. flush has priority over accept and transfer.
- Reset mid-operation: pending halves are lost; no partial beat is emitted afterwards.
- b_data and b_valid must remain stable while b_valid && !b_ready.

Optional Feature:
- Macro: FIFO_1D_64TO32_SKID_EN.
- Defined:
  - Adds a second 64-bit skid entry with its own 2-bit pending mask.
  - a_ready becomes a registered signal = !skid_full, with no combinational path from b_ready.
  - An accept goes to the main entry if the main entry is empty or freed this cycle and the skid is empty; otherwise it goes to the skid.
  - When the main entry frees and the skid is full, the skid moves to main at the same edge and skid_full clears.
  - A mask-00 beat never occupies the skid.
  - flush and rst clear both entries.
  - Latency from empty is still 1 cycle; throughput is unchanged.
- Undefined: base single-entry behaviour as above.

Decomposition:
- Shared package fifo_pkg holds:
  - HALF_W = 32 and WORD_W = 64.
  - Mask bit positions MASK_HI = 1, MASK_LO = 0.
  - Localparam encodings for EMPTY/HI/LO, for waveform decode.
- One natural sub-module, fifo_1d_64to32_entry: a 64-bit word plus 2-bit pending register, with load/clear/consume-half controls.
  - Instantiated once in the base build, twice with SKID_EN.

Test Plan:
- Reset then a_data = 0x11112222_33334444, mask 11, b_ready = 1 -> b emits 0x11112222 at t+1, then 0x33334444 at t+2; a_ready = 1 on cycle t+2.
- Back-to-back mask-11 beats A = 0xAAAA0001_AAAA0002, B = 0xBBBB0001_BBBB0002, b_ready = 1 -> output sequence AAAA0001, AAAA0002, BBBB0001, BBBB0002 with no bubbles.
- Masks 01 then 10 then 00 on words 0x1_2, 0x3_4, 0x5_6 -> outputs 0x00000002 then 0x00000003 only; the 00 beat produces nothing.
- b_ready held 0 for 5 cycles with HI pending -> b_data is stable at the upper half; a_ready = 0 (base build); no data is lost after release.
- Flush asserted while in LO with a_valid = 1 -> next cycle b_valid = 0; the flush-cycle beat is absent from the output.
- With FIFO_1D_64TO32_SKID_EN: b_ready = 0, push two mask-11 beats -> a_ready drops to 0 registered after the second; release yields 4 ordered halves, and a_ready never toggles in the same cycle as b_ready.
